// File: rtl/mux4_pkg.sv
// Shared definitions for the 4:1 mux scan sequencer.
// Contents: channel count, select width, FSM state type, channel index constants.
package mux4_pkg;

  localparam int NUM_CH = 4;
  localparam int SEL_W  = 2;

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } scan_state_t;

  localparam logic [SEL_W-1:0] CH0 = 2'b00;
  localparam logic [SEL_W-1:0] CH1 = 2'b01;
  localparam logic [SEL_W-1:0] CH2 = 2'b10;
  localparam logic [SEL_W-1:0] CH3 = 2'b11;

endpackage

// File: rtl/mux4_scan_ctrl_if.sv
// Bundle between the scan sequencer and its environment (mux + frame consumer).
// master: drives start, continuous, y_in; observes sel, frame, frame_valid, busy.
// slave : the sequencer side.
interface mux4_scan_ctrl_if;
  import mux4_pkg::*;

  logic              start;
  logic              continuous;
  logic              y_in;
  logic [SEL_W-1:0]  sel;
  logic [NUM_CH-1:0] frame;
  logic              frame_valid;
  logic              busy;

  modport master (
    output start, continuous, y_in,
    input  sel, frame, frame_valid, busy
  );

  modport slave (
    input  start, continuous, y_in,
    output sel, frame, frame_valid, busy
  );

endinterface

// File: rtl/scan_dwell_counter.sv
// Dwell timer for one mux channel. Counts up from 0 while en is high and
// wraps to 0 on its own at DWELL-1, so back-to-back dwells need no clear.
// Ports: clk, rst_n (sync, active-low), clear (force to 0), en (count),
//        terminal (comb, cnt == DWELL-1), cnt (current count).
module scan_dwell_counter #(
  parameter int DWELL = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             en,
  output logic             terminal,
  output logic [CNT_W-1:0] cnt
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DWELL - 1);

  assign terminal = (cnt == LAST_CNT);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= terminal ? '0 : cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/mux4_scan_ctrl.sv
// Sequencer for a 4:1 mux: steps sel through channels 0..3, holds each for
// DWELL cycles, samples y_in in the last cycle of each dwell and publishes
// the 4 samples as one frame with a single-cycle frame_valid pulse.
// Ports: clk, rst_n (sync, active-low), bus (mux4_scan_ctrl_if.slave).
//
// state | meaning
// IDLE  | sel parked at 0, waiting for start
// SCAN  | stepping channels; busy=1
module mux4_scan_ctrl
  import mux4_pkg::*;
#(
  parameter int DWELL = 4,
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  mux4_scan_ctrl_if.slave   bus
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DWELL - 1);

  scan_state_t       state_q, state_d;
  logic [SEL_W-1:0]  sel_q, sel_d;
  logic [NUM_CH-1:0] shadow_q, shadow_d;
  logic [NUM_CH-1:0] frame_q, frame_d;
  logic              frame_valid_q, frame_valid_d;
  logic              terminal;
  logic [CNT_W-1:0]  dwell_cnt;

  // Held clear in IDLE so the first SCAN cycle always starts a fresh dwell.
  scan_dwell_counter #(
    .DWELL (DWELL),
    .CNT_W (CNT_W)
  ) u_dwell (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (state_q == IDLE),
    .en       (state_q == SCAN),
    .terminal (terminal),
    .cnt      (dwell_cnt)
  );

  always_comb begin
    state_d       = state_q;
    sel_d         = sel_q;
    shadow_d      = shadow_q;
    frame_d       = frame_q;
    frame_valid_d = 1'b0;

    case (state_q)
      IDLE: begin
        sel_d = CH0;
        if (bus.start) state_d = SCAN;
      end
      SCAN: begin
        if (terminal) begin
          shadow_d[sel_q] = bus.y_in;
          if (sel_q == CH3) begin
            // shadow_d already holds the channel-3 sample in bit 3.
            frame_d       = shadow_d;
            frame_valid_d = 1'b1;
            sel_d         = CH0;
            if (!bus.continuous) state_d = IDLE;
          end else begin
            sel_d = SEL_W'(sel_q + 1'b1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      sel_q         <= CH0;
      shadow_q      <= '0;
      frame_q       <= '0;
      frame_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      sel_q         <= sel_d;
      shadow_q      <= shadow_d;
      frame_q       <= frame_d;
      frame_valid_q <= frame_valid_d;
    end
  end

  assign bus.sel         = sel_q;
  assign bus.frame       = frame_q;
  assign bus.frame_valid = frame_valid_q;
  assign bus.busy        = (state_q == SCAN);

  a_dwell_range : assert property (@(posedge clk) disable iff (!rst_n)
    dwell_cnt <= LAST_CNT);

endmodule

// File: tb/tb_mux4_scan_ctrl.sv
// Bench for mux4_scan_ctrl: DWELL=4 and DWELL=1 instances, each fed by a
// behavioural 4:1 mux driven from a per-instance data pattern.
module tb_mux4_scan_ctrl;
  import mux4_pkg::*;

  localparam int DA = 4;

  logic clk = 1'b0;
  logic rst_n_a, rst_n_b;
  logic [3:0] pat_a, pat_b;
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mux4_scan_ctrl_if bus_a ();
  mux4_scan_ctrl_if bus_b ();

  assign bus_a.y_in = pat_a[bus_a.sel];
  assign bus_b.y_in = pat_b[bus_b.sel];

  mux4_scan_ctrl #(.DWELL(DA), .CNT_W(16)) dut_a (
    .clk (clk), .rst_n (rst_n_a), .bus (bus_a.slave));
  mux4_scan_ctrl #(.DWELL(1), .CNT_W(16)) dut_b (
    .clk (clk), .rst_n (rst_n_b), .bus (bus_b.slave));

  typedef struct {
    logic       rst_n, start, cont;
    logic [3:0] pat;
    logic [1:0] sel;
    logic [3:0] frame;
    logic       fv, busy;
  } vec_t;

  vec_t vecs[22];

  // Reference model: position within a frame as a plain cycle count.
  bit         m_busy;
  int         m_t;
  logic [3:0] m_samples, m_frame;
  logic       m_fv;
  int         m_sel;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(string name, logic [7:0] act, logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic check_a(string tag, int c, int sel, logic [3:0] fr, logic fv, logic busy,
                         bit chk_frame);
    check($sformatf("%s sel c%0d", tag, c), 8'(bus_a.sel), 8'(sel));
    check($sformatf("%s fv c%0d", tag, c), 8'(bus_a.frame_valid), 8'(fv));
    check($sformatf("%s busy c%0d", tag, c), 8'(bus_a.busy), 8'(busy));
    if (chk_frame) check($sformatf("%s frame c%0d", tag, c), 8'(bus_a.frame), 8'(fr));
  endtask

  task automatic model_step();
    logic y;
    y = pat_a[m_sel];
    m_fv = 1'b0;
    if (!rst_n_a) begin
      m_busy = 0; m_t = 0; m_frame = '0; m_samples = '0;
    end else if (!m_busy) begin
      if (bus_a.start) begin m_busy = 1; m_t = 0; end
    end else begin
      if (m_t % DA == DA - 1) m_samples[m_t / DA] = y;
      if (m_t == 4 * DA - 1) begin
        m_frame = m_samples;
        m_fv    = 1'b1;
        m_t     = 0;
        if (!bus_a.continuous) m_busy = 0;
      end else begin
        m_t++;
      end
    end
    m_sel = m_busy ? m_t / DA : 0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{1'b0, 1'b0, 1'b0, 4'h0, 2'd0, 4'h0, 1'b0, 1'b0};
    vecs[1]  = '{1'b1, 1'b1, 1'b0, 4'h6, 2'd0, 4'h0, 1'b0, 1'b1};
    vecs[2]  = '{1'b1, 1'b0, 1'b0, 4'h6, 2'd1, 4'h0, 1'b0, 1'b1};
    vecs[3]  = '{1'b1, 1'b0, 1'b0, 4'h6, 2'd2, 4'h0, 1'b0, 1'b1};
    vecs[4]  = '{1'b1, 1'b0, 1'b0, 4'h6, 2'd3, 4'h0, 1'b0, 1'b1};
    vecs[5]  = '{1'b1, 1'b0, 1'b0, 4'h6, 2'd0, 4'h6, 1'b1, 1'b0};
    vecs[6]  = '{1'b1, 1'b0, 1'b0, 4'h6, 2'd0, 4'h6, 1'b0, 1'b0};
    vecs[7]  = '{1'b1, 1'b1, 1'b1, 4'hA, 2'd0, 4'h6, 1'b0, 1'b1};
    vecs[8]  = '{1'b1, 1'b0, 1'b1, 4'hA, 2'd1, 4'h6, 1'b0, 1'b1};
    vecs[9]  = '{1'b1, 1'b0, 1'b1, 4'hA, 2'd2, 4'h6, 1'b0, 1'b1};
    vecs[10] = '{1'b1, 1'b0, 1'b1, 4'hA, 2'd3, 4'h6, 1'b0, 1'b1};
    vecs[11] = '{1'b1, 1'b0, 1'b1, 4'hA, 2'd0, 4'hA, 1'b1, 1'b1};
    vecs[12] = '{1'b1, 1'b0, 1'b0, 4'hA, 2'd1, 4'hA, 1'b0, 1'b1};
    vecs[13] = '{1'b1, 1'b0, 1'b0, 4'hA, 2'd2, 4'hA, 1'b0, 1'b1};
    vecs[14] = '{1'b1, 1'b0, 1'b0, 4'hA, 2'd3, 4'hA, 1'b0, 1'b1};
    vecs[15] = '{1'b1, 1'b0, 1'b0, 4'hA, 2'd0, 4'hA, 1'b1, 1'b0};
    vecs[16] = '{1'b1, 1'b1, 1'b0, 4'h5, 2'd0, 4'hA, 1'b0, 1'b1};
    vecs[17] = '{1'b1, 1'b1, 1'b0, 4'h5, 2'd1, 4'hA, 1'b0, 1'b1};
    vecs[18] = '{1'b1, 1'b1, 1'b0, 4'h5, 2'd2, 4'hA, 1'b0, 1'b1};
    vecs[19] = '{1'b1, 1'b1, 1'b0, 4'h5, 2'd3, 4'hA, 1'b0, 1'b1};
    vecs[20] = '{1'b1, 1'b1, 1'b0, 4'h5, 2'd0, 4'h5, 1'b1, 1'b0};
    vecs[21] = '{1'b1, 1'b1, 1'b0, 4'h5, 2'd0, 4'h5, 1'b0, 1'b1};

    rst_n_a = 1'b0; rst_n_b = 1'b0;
    pat_a = 4'h0; pat_b = 4'h0;
    bus_a.start = 1'b0; bus_a.continuous = 1'b0;
    bus_b.start = 1'b0; bus_b.continuous = 1'b0;
    tick(); tick();
    rst_n_a = 1'b1;
    check_a("reset", 0, 0, 4'h0, 1'b0, 1'b0, 1'b1);

    // DWELL=1 vector table: stepping, continuous wrap, start held high.
    for (int i = 0; i < 22; i++) begin
      rst_n_b = vecs[i].rst_n;
      bus_b.start = vecs[i].start;
      bus_b.continuous = vecs[i].cont;
      pat_b = vecs[i].pat;
      tick();
      check($sformatf("vec%0d sel", i), 8'(bus_b.sel), 8'(vecs[i].sel));
      check($sformatf("vec%0d frame", i), 8'(bus_b.frame), 8'(vecs[i].frame));
      check($sformatf("vec%0d fv", i), 8'(bus_b.frame_valid), 8'(vecs[i].fv));
      check($sformatf("vec%0d busy", i), 8'(bus_b.busy), 8'(vecs[i].busy));
    end

    // Single shot, 1001, extra start pulses at cycles 3 and 8 are ignored.
    pat_a = 4'b1001; bus_a.continuous = 1'b0; bus_a.start = 1'b1;
    tick(); bus_a.start = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      check_a("single", c, (c <= 16) ? (c - 1) / 4 : 0,
              (c >= 17) ? 4'b1001 : 4'b0000, c == 17, c <= 16, 1'b1);
      bus_a.start = (c == 3 || c == 8);
      tick();
    end
    bus_a.start = 1'b0;

    // Continuous, pattern change to 0110 in frame 2 before channel 1 samples.
    bus_a.continuous = 1'b1; bus_a.start = 1'b1;
    tick(); bus_a.start = 1'b0;
    for (int c = 1; c <= 68; c++) begin
      logic [3:0] ef;
      ef = (c == 17) ? 4'b1001 : (c == 33) ? 4'b0111 : 4'b0110;
      check_a("cont", c, (c <= 64) ? ((c - 1) % 16) / 4 : 0, ef,
              c == 17 || c == 33 || c == 49 || c == 65, c <= 64,
              c == 17 || c == 33 || c == 49 || c >= 65);
      if (c == 24) pat_a = 4'b0110;
      if (c == 50) bus_a.continuous = 1'b0;
      tick();
    end

    // Continuous dropped during channel 1 of frame 2.
    pat_a = 4'b1001; bus_a.continuous = 1'b1; bus_a.start = 1'b1;
    tick(); bus_a.start = 1'b0;
    for (int c = 1; c <= 36; c++) begin
      check_a("drop", c, (c <= 32) ? ((c - 1) % 16) / 4 : 0, 4'b1001,
              c == 17 || c == 33, c <= 32, c == 17 || c >= 33);
      if (c == 22) bus_a.continuous = 1'b0;
      tick();
    end

    // Reset at cycle 10 of a scan, then a clean frame.
    pat_a = 4'b0011; bus_a.start = 1'b1;
    tick(); bus_a.start = 1'b0;
    for (int c = 1; c < 10; c++) tick();
    rst_n_a = 1'b0;
    tick();
    rst_n_a = 1'b1;
    check_a("midrst", 11, 0, 4'h0, 1'b0, 1'b0, 1'b1);
    pat_a = 4'b1100; bus_a.start = 1'b1;
    tick(); bus_a.start = 1'b0;
    for (int c = 1; c <= 18; c++) begin
      check_a("postrst", c, (c <= 16) ? (c - 1) / 4 : 0,
              (c >= 17) ? 4'b1100 : 4'b0000, c == 17, c <= 16, 1'b1);
      tick();
    end

    // Random stimulus against the reference model.
    rst_n_a = 1'b0;
    model_step();
    tick();
    check_a("rnd_rst", 0, m_sel, m_frame, m_fv, m_busy, 1'b1);
    for (int n = 0; n < 3000; n++) begin
      rst_n_a = ($urandom_range(0, 199) != 0);
      bus_a.start = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 7) == 0) bus_a.continuous = ~bus_a.continuous;
      if ($urandom_range(0, 9) == 0) pat_a = 4'($urandom_range(0, 15));
      model_step();
      tick();
      check_a("rnd", n, m_sel, m_frame, m_fv, m_busy, 1'b1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
